// File: rtl/alarm_clock.sv
// Alarm clock: 24h BCD timekeeping, set buttons, optional 12h display,
// loadable alarm with a timed ring and acknowledge.
module alarm_clock #(
   parameter int TICK_DIV  = 10,
   parameter int HOUR_MODE = 24,
   parameter int ALARM_MIN = 1
) (
   input  logic       clk10hz,
   input  logic       clr_n,
   input  logic       setH_n,
   input  logic       setM_n,
   input  logic       al_load,
   input  logic [7:0] al_hour,
   input  logic [7:0] al_min,
   input  logic       al_en,
   input  logic       al_ack,
   output logic [3:0] hourTens,
   output logic [3:0] hourMu,
   output logic [3:0] minTens,
   output logic [3:0] minMu,
   output logic [3:0] secTens,
   output logic [3:0] secMu,
   output logic       pm,
   output logic       sig1s,
   output logic       ring,
   output logic       al_err
);
   localparam int CW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int RING_TICKS = ALARM_MIN * 60;
   localparam int RW         = $clog2(RING_TICKS);

   typedef enum logic {IDLE, RINGING} ringState_t;

   logic [CW-1:0] cnt, cntNext;
   logic          tick;
   logic [7:0]    hourR, minR, secR;
   logic [7:0]    hourN, minN, secN;
   logic [7:0]    alHour, alMin;
   logic [7:0]    dispHour;
   logic [4:0]    hourBin, hourAdj;
   logic          dispPm, loadOk, match;
   ringState_t    state;
   logic [RW-1:0] ringCnt;

   function automatic logic [7:0] inc60(input logic [7:0] v);
      if (v[3:0] == 4'd9) return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] inc24(input logic [7:0] v);
      if (v == 8'h23) return 8'h00;
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic isBcd(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   assign tick    = (cnt == CW'(TICK_DIV - 1));
   assign cntNext = tick ? '0 : cnt + 1'b1;
   assign loadOk  = isBcd(al_hour) && isBcd(al_min) && (al_hour <= 8'h23) && (al_min <= 8'h59);

   // Next time of day: set buttons override normal counting and suppress carries
   always_comb begin
      hourN = hourR;
      minN  = minR;
      secN  = secR;
      if (tick) begin
         if (!setM_n || !setH_n) begin
            if (!setM_n) begin
               minN = inc60(minR);
               secN = 8'h00;
            end
            if (!setH_n) hourN = inc24(hourR);
         end else begin
            secN = inc60(secR);
            if (secR == 8'h59) begin
               minN = inc60(minR);
               if (minR == 8'h59) hourN = inc24(hourR);
            end
         end
      end
   end

   // Ring starts only on a counting tick that lands on the alarm minute
   assign match = tick && setH_n && setM_n && al_en &&
                  (secN == 8'h00) && (minN == alMin) && (hourN == alHour);

   // Display hour mapping; 12h mode folds 00 to 12 and 13-23 to 01-11
   always_comb begin
      hourBin  = 5'(hourN[7:4]) * 5'd10 + 5'(hourN[3:0]);
      hourAdj  = hourBin;
      dispHour = hourN;
      dispPm   = 1'b0;
      if (HOUR_MODE == 12) begin
         dispPm = (hourBin >= 5'd12);
         if (hourBin == 5'd0)       hourAdj = 5'd12;
         else if (hourBin > 5'd12)  hourAdj = hourBin - 5'd12;
         dispHour = (hourAdj >= 5'd10) ? {4'd1, 4'(hourAdj - 5'd10)} : {4'd0, hourAdj[3:0]};
      end
   end

   // Prescaler, time registers and registered display outputs
   always_ff @(posedge clk10hz or negedge clr_n) begin
      if (!clr_n) begin
         cnt      <= '0;
         hourR    <= 8'h00;
         minR     <= 8'h00;
         secR     <= 8'h00;
         hourTens <= 4'd0;
         hourMu   <= 4'd0;
         minTens  <= 4'd0;
         minMu    <= 4'd0;
         secTens  <= 4'd0;
         secMu    <= 4'd0;
         pm       <= 1'b0;
         sig1s    <= 1'b0;
      end else begin
         cnt      <= cntNext;
         hourR    <= hourN;
         minR     <= minN;
         secR     <= secN;
         hourTens <= dispHour[7:4];
         hourMu   <= dispHour[3:0];
         minTens  <= minN[7:4];
         minMu    <= minN[3:0];
         secTens  <= secN[7:4];
         secMu    <= secN[3:0];
         pm       <= dispPm;
         sig1s    <= (cntNext < CW'(TICK_DIV / 2));
      end
   end

   // Alarm register; malformed loads are dropped and flagged for one cycle
   always_ff @(posedge clk10hz or negedge clr_n) begin
      if (!clr_n) begin
         alHour <= 8'h00;
         alMin  <= 8'h00;
         al_err <= 1'b0;
      end else begin
         al_err <= al_load && !loadOk;
         if (al_load && loadOk) begin
            alHour <= al_hour;
            alMin  <= al_min;
         end
      end
   end

   // Ring FSM; a match outranks a same-cycle acknowledge
   always_ff @(posedge clk10hz or negedge clr_n) begin
      if (!clr_n) begin
         state   <= IDLE;
         ringCnt <= '0;
         ring    <= 1'b0;
      end else if (match) begin
         state   <= RINGING;
         ringCnt <= '0;
         ring    <= 1'b1;
      end else if (state == RINGING) begin
         if (al_ack || !al_en) begin
            state <= IDLE;
            ring  <= 1'b0;
         end else if (tick) begin
            if (ringCnt == RW'(RING_TICKS - 1)) begin
               state <= IDLE;
               ring  <= 1'b0;
            end else begin
               ringCnt <= ringCnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_alarm_clock.sv
// Directed bench: a 24h and a 12h instance share stimulus; table of set-button
// moves plus hand sequences for reset, alarm load, ring and acknowledge.
module tb_alarm_clock;
   localparam int TD = 4;

   logic clk = 1'b0;
   logic clr_n, setH_n, setM_n, al_load, al_en, al_ack;
   logic [7:0] al_hour, al_min;
   logic [3:0] hT24, hU24, mT24, mU24, sT24, sU24;
   logic [3:0] hT12, hU12, mT12, mU12, sT12, sU12;
   logic pm24, sig24, ring24, err24, pm12, sig12, ring12, err12;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   alarm_clock #(.TICK_DIV(TD), .HOUR_MODE(24), .ALARM_MIN(1)) u24 (
      .clk10hz(clk), .clr_n(clr_n), .setH_n(setH_n), .setM_n(setM_n),
      .al_load(al_load), .al_hour(al_hour), .al_min(al_min), .al_en(al_en), .al_ack(al_ack),
      .hourTens(hT24), .hourMu(hU24), .minTens(mT24), .minMu(mU24), .secTens(sT24), .secMu(sU24),
      .pm(pm24), .sig1s(sig24), .ring(ring24), .al_err(err24));

   alarm_clock #(.TICK_DIV(TD), .HOUR_MODE(12), .ALARM_MIN(1)) u12 (
      .clk10hz(clk), .clr_n(clr_n), .setH_n(setH_n), .setM_n(setM_n),
      .al_load(al_load), .al_hour(al_hour), .al_min(al_min), .al_en(al_en), .al_ack(al_ack),
      .hourTens(hT12), .hourMu(hU12), .minTens(mT12), .minMu(mU12), .secTens(sT12), .secMu(sU12),
      .pm(pm12), .sig1s(sig12), .ring(ring12), .al_err(err12));

   typedef struct {
      logic        sh;
      logic        sm;
      int          n;
      logic [23:0] t24;
      logic [7:0]  h12;
      logic        pm;
   } vec_t;

   vec_t tbl[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      edges(n * TD);
   endtask

   task automatic doReset();
      clr_n = 1'b0;
      #4;
      clr_n = 1'b1;
   endtask

   function automatic logic [23:0] t24();
      return {hT24, hU24, mT24, mU24, sT24, sU24};
   endfunction

   initial begin
      int hi;
      clr_n = 1'b0; setH_n = 1'b1; setM_n = 1'b1; al_load = 1'b0;
      al_hour = 8'h00; al_min = 8'h00; al_en = 1'b0; al_ack = 1'b0;

      tbl[0]  = '{1'b0, 1'b1, 10, 24'h100000, 8'h10, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 59, 24'h105900, 8'h10, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 30, 24'h105930, 8'h10, 1'b0};
      tbl[3]  = '{1'b1, 1'b0,  3, 24'h100200, 8'h10, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 14, 24'h000200, 8'h12, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 13, 24'h130200, 8'h01, 1'b1};
      tbl[6]  = '{1'b1, 1'b0,  3, 24'h130500, 8'h01, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 11, 24'h001600, 8'h12, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 23, 24'h231600, 8'h11, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 43, 24'h235900, 8'h11, 1'b1};
      tbl[10] = '{1'b1, 1'b1, 59, 24'h235959, 8'h11, 1'b1};
      tbl[11] = '{1'b1, 1'b1,  1, 24'h000000, 8'h12, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 12, 24'h120000, 8'h12, 1'b1};
      tbl[13] = '{1'b1, 1'b1, 61, 24'h120101, 8'h12, 1'b1};
      tbl[14] = '{1'b0, 1'b1,  1, 24'h130101, 8'h01, 1'b1};

      // Reset state of both instances
      #12;
      check("reset24", {t24(), pm24, sig24, ring24, err24}, 32'h0);
      check("reset12", {hT12, hU12, mT12, mU12, sT12, sU12, pm12, sig12, ring12, err12}, 32'h0);
      clr_n = 1'b1;

      // First edge: 12h shows 12; blink duty and first-tick latency
      hi = 0;
      for (int i = 1; i <= TD; i++) begin
         edges(1);
         hi += int'(sig24);
         if (i == 1) check("first12", {hT12, hU12, pm12}, {8'h12, 1'b0});
         if (i == TD - 1) check("preTick", t24(), 24'h000000);
      end
      check("firstTick", t24(), 24'h000001);
      check("sig1sDuty", hi, TD / 2);

      // Table of set-button moves from 00:00:00
      doReset();
      for (int i = 0; i < 15; i++) begin
         setH_n = tbl[i].sh;
         setM_n = tbl[i].sm;
         ticks(tbl[i].n);
         check($sformatf("vec%0d_24", i), {t24(), pm24}, {tbl[i].t24, 1'b0});
         check($sformatf("vec%0d_12", i), {hT12, hU12, mT12, mU12, pm12},
               {tbl[i].h12, tbl[i].t24[15:8], tbl[i].pm});
      end
      setH_n = 1'b1; setM_n = 1'b1;

      // Alarm loads: one valid, two rejected
      doReset();
      al_load = 1'b1; al_hour = 8'h07; al_min = 8'h30;
      edges(1);
      check("errValid", err24, 1'b0);
      al_hour = 8'h24;
      edges(1);
      check("errHour", err24, 1'b1);
      al_load = 1'b0;
      edges(1);
      check("errPulse", err24, 1'b0);
      al_load = 1'b1; al_hour = 8'h07; al_min = 8'h5A;
      edges(1);
      check("errMin", err24, 1'b1);
      al_load = 1'b0; al_en = 1'b1;
      setH_n = 1'b0; ticks(7); setH_n = 1'b1;
      setM_n = 1'b0; ticks(29); setM_n = 1'b1;
      check("setTo0729", t24(), 24'h072900);
      ticks(59);
      edges(TD - 1);
      check("ringPre", ring24, 1'b0);
      edges(1);
      check("ringRise", {t24(), ring24}, {24'h073000, 1'b1});
      ticks(59);
      check("ringHold", ring24, 1'b1);
      ticks(1);
      check("ringTimeout", {t24(), ring24}, {24'h073100, 1'b0});

      // Set-button edit landing on the alarm minute must not ring
      setM_n = 1'b0; ticks(59);
      check("editNoRing", {t24(), ring24}, {24'h073000, 1'b0});
      ticks(59); setM_n = 1'b1;
      ticks(60);
      check("ringRise2", ring24, 1'b1);
      ticks(10);
      al_ack = 1'b1; edges(1); al_ack = 1'b0;
      check("ackFall", {t24(), ring24}, {24'h073010, 1'b0});
      edges(TD - 1);

      // Acknowledge coinciding with the match tick: ring still starts
      setM_n = 1'b0; ticks(59); setM_n = 1'b1;
      ticks(59);
      edges(TD - 1);
      al_ack = 1'b1; edges(1); al_ack = 1'b0;
      check("matchBeatsAck", {t24(), ring24}, {24'h073000, 1'b1});

      // Asynchronous reset while ringing
      #3 clr_n = 1'b0;
      #1;
      check("asyncClr", {t24(), ring24, pm12, hT12, hU12}, 32'h0);
      #2 clr_n = 1'b1;
      @(negedge clk);

      // Dropping enable stops the ring
      al_load = 1'b1; al_hour = 8'h00; al_min = 8'h01;
      @(posedge clk); #1;
      al_load = 1'b0;
      ticks(60);
      check("ringRise3", ring24, 1'b1);
      al_en = 1'b0; edges(1);
      check("enDrop", ring24, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
